load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the 256x32 word-addressed data memory.
- Converts byte-addressed RV32 loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory transactions.
- Sub-word stores use read-modify-write. Load data is sign- or zero-extended.
- Stalls the pipeline while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles one memory request may stay pending before abort.
- ADDR_WORDS, 256, memory depth in words; word index is wrapped modulo this value.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_read  in  1  load request; held by pipeline while lsu_stall=1.
- cpu_write  in  1  store request; held while lsu_stall=1.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data; low byte/half used for SB/SH.
- func3  in  3  RV32 width/sign code.
- lsu_stall  out  1  pipeline freeze.
- load_data  out  32  extended load result, valid in DONE.
- misaligned  out  1  misaligned access flag, valid in DONE.
- mem_timeout  out  1  sticky timeout flag.
- mem_read  out  1  memory read enable (registered).
- mem_write  out  1  memory write enable (registered).
- mem_address  out  32  word index = cpu_addr[31:2] mod ADDR_WORDS.
- mem_wdata  out  32  word to write.
- mem_func3  out  3  always 3'b010; word access.
- mem_rdata  in  32  memory read data.
- busywait  in  1  memory busy.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0 except mem_func3=3'b010; timeout counter cleared.
- States: IDLE, RD, RMW_RD, WR, DONE.
- IDLE:
  - cpu_read=1 and cpu_write=1 together: treated as a store; the read is ignored.
  - Load -> RD with mem_read=1.
  - SW -> WR with mem_write=1 and mem_wdata=cpu_wdata.
  - SB/SH -> RMW_RD with mem_read=1.
  - Misaligned access -> DONE directly, no memory access, misaligned=1 (see Optional Feature).
  - Address, data and func3 are latched on leaving IDLE.
- Memory wait rule, applies to RD, RMW_RD and WR:
  - Request is held until the first rising edge where busywait=0, with the request asserted on at least one earlier edge.
  - The issue-cycle busywait value is ignored.
  - On that edge the request is deasserted.
- RD: on completion, capture mem_rdata. Select byte addr[1:0] or half addr[1]. Extend per func3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero. Then -> DONE.
- RMW_RD: on completion, merge the latched store byte/half into mem_rdata at the addressed lane. Assert mem_write with the merged word -> WR.
- WR: on completion -> DONE.
- DONE: one cycle, lsu_stall=0, load_data/misaligned valid. Pipeline advances on this edge. -> IDLE. A request still visible in DONE is not re-issued.
- lsu_stall = (IDLE and request and access not rejected) or state in {RD, RMW_RD, WR}. Stall is combinational, so it is high in the request's first cycle.
- Latency with a 1-cycle-busy memory: load 3 cycles including DONE; SW 3; SB/SH 5.
- Timeout:
  - Counter increments each cycle in a wait state and clears on each state change.
  - Reaching TIMEOUT_CYCLES: drop mem_read/mem_write, set mem_timeout=1 (sticky until reset), go to DONE with load_data=0. No write is performed on an RMW abort.
- Illegal func3 (011, 110, 111): treated as word access.
- Reset mid-transaction: immediate return to IDLE, requests dropped.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, produce the IDLE->DONE path: misaligned=1, no memory traffic, stall high for the request cycle only, load_data=0.
- Undefined: low address bits are forced to natural alignment (half: bit0=0; word: bits1:0=0), the access proceeds normally, and misaligned is tied 0.

Test Plan:
- After reset, SW addr 0x10 data 0xDEADBEEF -> mem_write=1, mem_address=4, mem_wdata=0xDEADBEEF; stall drops in DONE.
- LB at 0x13 with memory word 4=0xDEADBEEF -> load_data=0xFFFFFFDE; LBU same address -> 0x000000DE; LH at 0x12 -> 0xFFFFDEAD.
- SB 0x55 at 0x11 over 0xDEADBEEF -> one read then one write of 0xDEAD55EF; subsequent LW at 0x10 returns 0xDEAD55EF.
- busywait held high forever on a load with TIMEOUT_CYCLES=8 -> mem_read drops after 8 wait cycles, mem_timeout=1, load_data=0, stall released.
- Reset pulse while in RMW_RD -> mem_read=0 and lsu_stall=0 immediately; no write issued; memory word unchanged.
- LW at 0x0000_0402 -> with macro: misaligned=1, no mem_read. Without macro: mem_address=0 (0x100 wrapped mod 256), normal load.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges the pipeline MEM stage and a word-addressed data memory. Byte-
// addressed RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) become whole-word
// memory transactions. Sub-word stores use a read-modify-write sequence.
// Load results are sign- or zero-extended. The pipeline is frozen while a
// transaction is in flight.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses go straight to DONE with
//               misaligned=1 and produce no memory traffic.
//   undefined : low address bits are forced to natural alignment and the
//               access proceeds normally; misaligned stays 0.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a memory request may stay pending before abort
//   ADDR_WORDS      memory depth in words; word index wraps modulo this
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   cpu_read     in   load request (held while lsu_stall=1)
//   cpu_write    in   store request (held while lsu_stall=1)
//   cpu_addr     in   byte address
//   cpu_wdata    in   store data
//   func3        in   RV32 width/sign code
//   lsu_stall    out  pipeline freeze
//   load_data    out  extended load result, valid in DONE
//   misaligned   out  misaligned access flag, valid in DONE
//   mem_timeout  out  sticky timeout flag
//   mem_read     out  memory read enable (registered)
//   mem_write    out  memory write enable (registered)
//   mem_address  out  word index into the memory
//   mem_wdata    out  word to write
//   mem_func3    out  constant word-access code 3'b010
//   mem_rdata    in   memory read data
//   busywait     in   memory busy
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_WORDS     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  func3,
   output logic        lsu_stall,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        mem_timeout,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_func3,
   input  logic [31:0] mem_rdata,
   input  logic        busywait
);

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]      DEPTH    = 32'(ADDR_WORDS);

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RMW_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       lane_q;
   logic [1:0]       size_q;
   logic             sign_q;
   logic [31:0]      wdata_q;

   logic [1:0]  req_size;
   logic [1:0]  req_lane;
   logic        req_mis;
   logic [31:0] word_index;
   logic        req_any;

   logic [4:0]  shamt;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] lane_mask;
   logic [31:0] ext_data;
   logic [31:0] merged;
   logic        mem_done;
   logic        timed_out;

   assign mem_func3 = 3'b010;
   assign req_any   = cpu_read | cpu_write;

   // Word index ignores the two byte-offset bits; the forced alignment below
   // only ever touches those bits, so the raw address can be used here.
   assign word_index = {2'b00, cpu_addr[31:2]} % DEPTH;

   // The request's first cycle is stalled combinationally so the pipeline
   // holds before the FSM has even left IDLE.
   assign lsu_stall = ((state == S_IDLE) && req_any) ||
                      (state == S_RD) || (state == S_RMW_RD) || (state == S_WR);

   // A wait state completes only after its issue cycle; the busywait seen in
   // the issue cycle may still reflect the memory's previous idle state.
   assign mem_done  = (wait_cnt != '0) && !busywait;
   assign timed_out = (wait_cnt == CNT_LAST);

   // Decode the access width from func3 and work out the naturally aligned
   // lane. Illegal codes (011/110/111) fall into the word case.
   always_comb begin
      req_size = SZ_WORD;
      req_lane = 2'b00;
      req_mis  = 1'b0;
      case (func3[1:0])
         2'b00: begin
            req_size = SZ_BYTE;
            req_lane = cpu_addr[1:0];
         end
         2'b01: begin
            req_size = SZ_HALF;
            req_lane = {cpu_addr[1], 1'b0};
         end
         default: begin
            req_size = SZ_WORD;
            req_lane = 2'b00;
         end
      endcase
`ifdef LSU_MISALIGN_CHECK_EN
      req_mis = ((req_size == SZ_HALF) && cpu_addr[0]) ||
                ((req_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
`else
      req_mis = 1'b0;
`endif
   end

   // Lane extraction for loads and lane merge for sub-word stores, both based
   // on the latched lane/size so they are stable while the memory responds.
   always_comb begin
      shamt     = {lane_q, 3'b000};
      rd_byte   = mem_rdata[shamt +: 8];
      rd_half   = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      lane_mask = 32'hFFFF_FFFF;
      ext_data  = mem_rdata;
      case (size_q)
         SZ_BYTE: begin
            ext_data  = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            lane_mask = 32'h0000_00FF;
         end
         SZ_HALF: begin
            ext_data  = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            lane_mask = 32'h0000_FFFF;
         end
         default: begin
            ext_data  = mem_rdata;
            lane_mask = 32'hFFFF_FFFF;
         end
      endcase
      merged = (mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
   end

   // Main transaction FSM. All memory-side and result outputs are registered
   // here. A simultaneous read and write request is handled as a store.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         lane_q      <= 2'b00;
         size_q      <= SZ_BYTE;
         sign_q      <= 1'b0;
         wdata_q     <= 32'h0;
         load_data   <= 32'h0;
         misaligned  <= 1'b0;
         mem_timeout <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= 32'h0;
         mem_wdata   <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               if (req_any) begin
                  lane_q     <= req_lane;
                  size_q     <= req_size;
                  sign_q     <= ~func3[2];
                  wdata_q    <= cpu_wdata;
                  load_data  <= 32'h0;
                  misaligned <= 1'b0;
                  if (req_mis) begin
                     misaligned <= 1'b1;
                     state      <= S_DONE;
                  end else if (cpu_write) begin
                     mem_address <= word_index;
                     if (req_size == SZ_WORD) begin
                        mem_write <= 1'b1;
                        mem_wdata <= cpu_wdata;
                        state     <= S_WR;
                     end else begin
                        mem_read <= 1'b1;
                        state    <= S_RMW_RD;
                     end
                  end else begin
                     mem_address <= word_index;
                     mem_read    <= 1'b1;
                     state       <= S_RD;
                  end
               end
            end

            S_RD: begin
               if (mem_done) begin
                  mem_read  <= 1'b0;
                  load_data <= ext_data;
                  wait_cnt  <= '0;
                  state     <= S_DONE;
               end else if (timed_out) begin
                  mem_read    <= 1'b0;
                  mem_timeout <= 1'b1;
                  load_data   <= 32'h0;
                  wait_cnt    <= '0;
                  state       <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            // On completion the merged word goes straight out as the write;
            // an abort here never reaches WR so memory stays untouched.
            S_RMW_RD: begin
               if (mem_done) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b1;
                  mem_wdata <= merged;
                  wait_cnt  <= '0;
                  state     <= S_WR;
               end else if (timed_out) begin
                  mem_read    <= 1'b0;
                  mem_timeout <= 1'b1;
                  load_data   <= 32'h0;
                  wait_cnt    <= '0;
                  state       <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            S_WR: begin
               if (mem_done) begin
                  mem_write <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= S_DONE;
               end else if (timed_out) begin
                  mem_write   <= 1'b0;
                  mem_timeout <= 1'b1;
                  load_data   <= 32'h0;
                  wait_cnt    <= '0;
                  state       <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            // The pipeline advances on this edge, so any request still
            // visible now belongs to the finished instruction and is dropped.
            S_DONE: begin
               wait_cnt <= '0;
               state    <= S_IDLE;
            end

            default: begin
               wait_cnt <= '0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
